// File: rtl/uart_pkg.sv
// uart_pkg: receiver state encoding, oversampling default and parity helper.
// The parity function is shared with the UART transmitter.
package uart_pkg;

    localparam int OVERSAMPLE_DEF = 16;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;

    // Expected parity bit over 7 or 8 data bits.
    function automatic logic parity_bit(
        input logic [7:0] data,
        input logic       bit8,
        input logic       odd_n_even
    );
        logic [7:0] d;
        d = bit8 ? data : {1'b0, data[6:0]};
        return odd_n_even ^ (^d);
    endfunction

endpackage

// File: rtl/uart_rx_sync_vote.sv
// uart_rx_sync_vote: rx synchronizer plus 3-sample majority vote.
// The vote shift register advances only on baud_pulse.
module uart_rx_sync_vote
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic baud_pulse,
    input  logic rx,
    output logic rx_sync,
    output logic vote
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [2:0]             vote_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '1;
            vote_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
            if (baud_pulse) begin
                vote_q <= {vote_q[1:0], sync_q[SYNC_STAGES-1]};
            end
        end
    end

    assign rx_sync = sync_q[SYNC_STAGES-1];
    assign vote    = (vote_q[0] & vote_q[1])
                   | (vote_q[0] & vote_q[2])
                   | (vote_q[1] & vote_q[2]);

endmodule

// File: rtl/uart_rx_async.sv
// uart_rx_async: oversampling UART receiver with parity/framing/overrun status.
// Optional break detection (brk_det port) with UART_RX_BREAK_DETECT_EN.
module uart_rx_async
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE   = OVERSAMPLE_DEF,
    parameter int SAMPLE_POINT = 7,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       baud_pulse,
    input  logic       rx,
    input  logic       bit8,
    input  logic       parity_en,
    input  logic       odd_n_even,
    input  logic       read_rx,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    output logic       parity_err,
    output logic       framing_err,
`ifdef UART_RX_BREAK_DETECT_EN
    output logic       brk_det,
`endif
    output logic       overflow
);

    localparam int            SW   = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] SP   = SW'(SAMPLE_POINT);
    localparam logic [SW-1:0] SMAX = SW'(OVERSAMPLE - 1);

    rx_state_t     state, state_n;
    logic [SW-1:0] samp_cnt, samp_cnt_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shreg, shreg_n;
    logic          par_q, par_n;
    logic          brk_wait, brk_wait_n;
    logic          rx_sync, vote;
    logic          at_sp, last_bit, done, par_mis, is_brk;

    uart_rx_sync_vote #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_vote (
        .clk       (clk),
        .reset     (reset),
        .baud_pulse(baud_pulse),
        .rx        (rx),
        .rx_sync   (rx_sync),
        .vote      (vote)
    );

    assign at_sp    = baud_pulse && (samp_cnt == SP);
    assign last_bit = (bit_cnt == (bit8 ? 3'd7 : 3'd6));
    assign done     = at_sp && (state == RX_STOP);
    assign par_mis  = (par_q != parity_bit(shreg, bit8, odd_n_even));

`ifdef UART_RX_BREAK_DETECT_EN
    assign is_brk = done && (shreg == 8'h00)
                  && !(parity_en && par_q) && !vote;
`else
    assign is_brk = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RX_IDLE;
            samp_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_q    <= 1'b0;
            brk_wait <= 1'b0;
        end else begin
            state    <= state_n;
            samp_cnt <= samp_cnt_n;
            bit_cnt  <= bit_cnt_n;
            shreg    <= shreg_n;
            par_q    <= par_n;
            brk_wait <= brk_wait_n;
        end
    end

    always_comb begin
        state_n    = state;
        samp_cnt_n = samp_cnt;
        bit_cnt_n  = bit_cnt;
        shreg_n    = shreg;
        par_n      = par_q;
        brk_wait_n = brk_wait;
        if (baud_pulse) begin
            samp_cnt_n = (samp_cnt == SMAX) ? '0 : samp_cnt + 1'b1;
            unique case (state)
                RX_IDLE: begin
                    // After a break the line must return high first.
                    if (brk_wait) begin
                        if (rx_sync) brk_wait_n = 1'b0;
                    end else if (!rx_sync) begin
                        state_n    = RX_START;
                        samp_cnt_n = '0;
                    end
                end
                RX_START: begin
                    if (at_sp) begin
                        if (vote) begin
                            state_n = RX_IDLE;
                        end else begin
                            state_n   = RX_DATA;
                            bit_cnt_n = '0;
                            shreg_n   = '0;
                        end
                    end
                end
                RX_DATA: begin
                    if (at_sp) begin
                        shreg_n[bit_cnt] = vote;
                        bit_cnt_n        = bit_cnt + 1'b1;
                        if (last_bit) begin
                            state_n = parity_en ? RX_PARITY : RX_STOP;
                        end
                    end
                end
                RX_PARITY: begin
                    if (at_sp) begin
                        par_n   = vote;
                        state_n = RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (at_sp) begin
                        state_n    = RX_IDLE;
                        brk_wait_n = is_brk;
                    end
                end
                default: state_n = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data     <= '0;
            rx_rdy      <= 1'b0;
            parity_err  <= 1'b0;
            framing_err <= 1'b0;
            overflow    <= 1'b0;
        end else if (done && !is_brk) begin
            if (rx_rdy && !read_rx) begin
                overflow <= 1'b1;
            end else begin
                rx_data     <= shreg;
                rx_rdy      <= 1'b1;
                parity_err  <= parity_en && par_mis;
                framing_err <= !vote;
                overflow    <= 1'b0;
            end
        end else if (read_rx) begin
            rx_rdy      <= 1'b0;
            parity_err  <= 1'b0;
            framing_err <= 1'b0;
            overflow    <= 1'b0;
        end
    end

`ifdef UART_RX_BREAK_DETECT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            brk_det <= 1'b0;
        end else if (is_brk) begin
            brk_det <= 1'b1;
        end else if (read_rx) begin
            brk_det <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_async.sv
// tb_uart_rx_async: directed vector table, corner sequences and random frames
// checked against a frame-level receiver model.
`timescale 1ns/1ps
module tb_uart_rx_async;

    logic       clk        = 1'b0;
    logic       reset      = 1'b1;
    logic       baud_pulse = 1'b0;
    logic       rx         = 1'b1;
    logic       bit8       = 1'b1;
    logic       parity_en  = 1'b0;
    logic       odd_n_even = 1'b0;
    logic       read_rx    = 1'b0;
    logic [7:0] rx_data;
    logic       rx_rdy, parity_err, framing_err, overflow;
`ifdef UART_RX_BREAK_DETECT_EN
    logic       brk_det;
`endif

    int checks = 0;
    int errors = 0;

    uart_rx_async dut (
        .clk        (clk),
        .reset      (reset),
        .baud_pulse (baud_pulse),
        .rx         (rx),
        .bit8       (bit8),
        .parity_en  (parity_en),
        .odd_n_even (odd_n_even),
        .read_rx    (read_rx),
        .rx_data    (rx_data),
        .rx_rdy     (rx_rdy),
        .parity_err (parity_err),
        .framing_err(framing_err),
`ifdef UART_RX_BREAK_DETECT_EN
        .brk_det    (brk_det),
`endif
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Baud enable every 4 clocks; pcnt counts enables seen by the DUT.
    int   bcnt    = 0;
    int   pcnt    = 0;
    logic bp_last = 1'b0;
    always @(posedge clk) begin
        bcnt       <= (bcnt == 3) ? 0 : bcnt + 1;
        baud_pulse <= (bcnt == 3);
        pcnt       <= pcnt + (baud_pulse ? 1 : 0);
        bp_last    <= baud_pulse;
    end

    logic rdy_q   = 1'b0;
    int   rise_pc = -1;
    logic rise_bp = 1'b0;
    always @(negedge clk) begin
        if (rx_rdy && !rdy_q) begin
            rise_pc = pcnt;
            rise_bp = bp_last;
        end
        rdy_q = rx_rdy;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(string tag, logic [7:0] ed, logic erdy,
                             logic epe, logic efe, logic eov);
        chk({tag, ".data"}, 32'(rx_data), 32'(ed));
        chk({tag, ".rdy"}, 32'(rx_rdy), 32'(erdy));
        chk({tag, ".perr"}, 32'(parity_err), 32'(epe));
        chk({tag, ".ferr"}, 32'(framing_err), 32'(efe));
        chk({tag, ".ovf"}, 32'(overflow), 32'(eov));
    endtask

    // Per-baud-pulse line waveform: one entry per enable period.
    bit   wave[$];
    int   frame_pc = 0;
    event frame_ev;

    task automatic wait_pulse();
        int n;
        n = 0;
        @(posedge clk);
        while (baud_pulse !== 1'b1 && n < 16) begin
            @(posedge clk);
            n++;
        end
    endtask

    task automatic play();
        wait_pulse();
        @(negedge clk);
        frame_pc = pcnt;
        ->frame_ev;
        foreach (wave[j]) begin
            if (j > 0) begin
                wait_pulse();
                @(negedge clk);
            end
            rx = wave[j];
        end
        wait_pulse();
        @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic push_n(bit v, int n);
        repeat (n) wave.push_back(v);
    endtask

    // Frame per UART rules; a bad stop bit is low for 12 of 16 periods.
    task automatic build_frame(logic [7:0] d, bit b8, bit pen, bit odd,
                               bit flip, bit sok);
        int         nb;
        logic [7:0] md;
        nb = b8 ? 8 : 7;
        md = b8 ? d : (d & 8'h7F);
        wave.delete();
        push_n(1'b0, 16);
        for (int i = 0; i < nb; i++) push_n(md[i], 16);
        if (pen) push_n(odd ^ (^md) ^ flip, 16);
        if (sok) push_n(1'b1, 16);
        else begin
            push_n(1'b0, 12);
            push_n(1'b1, 4);
        end
        push_n(1'b1, 32);
    endtask

    task automatic set_fmt(bit b8, bit pen, bit odd);
        @(negedge clk);
        bit8       = b8;
        parity_en  = pen;
        odd_n_even = odd;
    endtask

    task automatic send(logic [7:0] d, bit b8, bit pen, bit odd,
                        bit flip, bit sok);
        set_fmt(b8, pen, odd);
        build_frame(d, b8, pen, odd, flip, sok);
        play();
    endtask

    task automatic do_read();
        @(negedge clk);
        read_rx = 1'b1;
        @(negedge clk);
        read_rx = 1'b0;
    endtask

    task automatic coincident_read(int off);
        int target;
        int n;
        n = 0;
        @(frame_ev);
        target = frame_pc + off;
        while (!(baud_pulse === 1'b1 && pcnt == target - 1) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("coin.reach", 32'(n < 4000), 32'd1);
        read_rx = 1'b1;
        @(negedge clk);
        read_rx = 1'b0;
    endtask

    // Frame-level reference model of the status registers.
    logic [7:0] m_data = 8'h00;
    logic       m_rdy  = 1'b0;
    logic       m_pe   = 1'b0;
    logic       m_fe   = 1'b0;
    logic       m_ov   = 1'b0;

    task automatic m_read();
        m_rdy = 1'b0;
        m_pe  = 1'b0;
        m_fe  = 1'b0;
        m_ov  = 1'b0;
    endtask

    task automatic m_complete(logic [7:0] d, logic pe, logic fe);
        if (m_rdy) begin
            m_ov = 1'b1;
        end else begin
            m_data = d;
            m_rdy  = 1'b1;
            m_pe   = pe;
            m_fe   = fe;
            m_ov   = 1'b0;
        end
    endtask

    typedef struct {
        logic [7:0] d;
        bit         b8;
        bit         pen;
        bit         odd;
        bit         flip;
        bit         sok;
        bit         rd;
        logic [7:0] ed;
        bit         erdy;
        bit         epe;
        bit         efe;
        bit         eov;
    } vec_t;

    vec_t tbl[10];
    int   stop_off = 0;

    initial begin
        logic [7:0] last;
        int         off;

        tbl[0] = '{8'hA5, 1, 0, 0, 0, 1, 0, 8'hA5, 1, 0, 0, 0};
        tbl[1] = '{8'h35, 0, 1, 1, 0, 1, 1, 8'h35, 1, 0, 0, 0};
        tbl[2] = '{8'h35, 0, 1, 1, 1, 1, 1, 8'h35, 1, 1, 0, 0};
        tbl[3] = '{8'h5A, 1, 0, 0, 0, 0, 1, 8'h5A, 1, 0, 1, 0};
        tbl[4] = '{8'h11, 1, 0, 0, 0, 1, 1, 8'h11, 1, 0, 0, 0};
        tbl[5] = '{8'h22, 1, 0, 0, 0, 1, 0, 8'h11, 1, 0, 0, 1};
        tbl[6] = '{8'hFF, 1, 1, 0, 0, 1, 1, 8'hFF, 1, 0, 0, 0};
        tbl[7] = '{8'h7F, 0, 1, 0, 1, 1, 1, 8'h7F, 1, 1, 0, 0};
        tbl[8] = '{8'hC3, 0, 0, 0, 0, 1, 1, 8'h43, 1, 0, 0, 0};
        tbl[9] = '{8'h00, 1, 1, 1, 0, 1, 0, 8'h43, 1, 0, 0, 1};

        reset = 1'b1;
        repeat (4) @(negedge clk);
        check_all("reset", 8'h00, 0, 0, 0, 0);
`ifdef UART_RX_BREAK_DETECT_EN
        chk("reset.brk", 32'(brk_det), 32'd0);
`endif
        reset = 1'b0;
        repeat (8) @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            if (tbl[i].rd) do_read();
            send(tbl[i].d, tbl[i].b8, tbl[i].pen, tbl[i].odd,
                 tbl[i].flip, tbl[i].sok);
            check_all($sformatf("vec%0d", i), tbl[i].ed, tbl[i].erdy,
                      tbl[i].epe, tbl[i].efe, tbl[i].eov);
            if (i == 0) begin
                // rx_rdy must rise one clk after an enable inside the stop bit.
                off = rise_pc - frame_pc;
                stop_off = off;
                chk("lat.after_pulse", 32'(rise_bp), 32'd1);
                chk("lat.in_stop_bit", 32'(off > 144 && off <= 160), 32'd1);
            end
        end

        do_read();
        check_all("read_clr", 8'h43, 0, 0, 0, 0);

        send(8'h11, 1, 0, 0, 0, 1);
        send(8'h44, 1, 0, 0, 0, 1);
        check_all("ovf", 8'h11, 1, 0, 0, 1);
        fork
            send(8'h22, 1, 0, 0, 0, 1);
            coincident_read(stop_off);
        join
        check_all("coin", 8'h22, 1, 0, 0, 0);

        do_read();
        wave.delete();
        push_n(1'b0, 3);
        push_n(1'b1, 64);
        play();
        chk("glitch.rdy", 32'(rx_rdy), 32'd0);
        send(8'h3C, 1, 0, 0, 0, 1);
        check_all("after_glitch", 8'h3C, 1, 0, 0, 0);

        do_read();
        set_fmt(1, 0, 0);
        build_frame(8'hF0, 1, 0, 0, 0, 1);
        wave[16 + 7] = 1'b1;
        wave[48 + 6] = 1'b1;
        play();
        check_all("spike", 8'hF0, 1, 0, 0, 0);

        send(8'h5A, 1, 0, 0, 0, 0);
        check_all("pre_rst", 8'hF0, 1, 0, 0, 1);
        set_fmt(1, 0, 0);
        build_frame(8'h99, 1, 0, 0, 0, 1);
        wave = wave[0:79];
        play();
        @(negedge clk);
        reset = 1'b1;
        rx    = 1'b1;
        repeat (2) @(negedge clk);
        check_all("mid_rst", 8'h00, 0, 0, 0, 0);
        reset = 1'b0;
        repeat (160) @(negedge clk);
        chk("mid_rst.no_partial", 32'(rx_rdy), 32'd0);
        send(8'h96, 1, 0, 0, 0, 1);
        check_all("after_rst", 8'h96, 1, 0, 0, 0);
        last = 8'h96;

`ifdef UART_RX_BREAK_DETECT_EN
        do_read();
        set_fmt(1, 0, 0);
        wave.delete();
        push_n(1'b0, 12 * 16);
        push_n(1'b1, 48);
        play();
        chk("brk.det", 32'(brk_det), 32'd1);
        check_all("brk", 8'h96, 0, 0, 0, 0);
        do_read();
        chk("brk.clr", 32'(brk_det), 32'd0);
        send(8'h81, 1, 0, 0, 0, 1);
        check_all("after_brk", 8'h81, 1, 0, 0, 0);
        last = 8'h81;
`endif

        do_read();
        m_read();
        m_data = last;
        for (int r = 0; r < 24; r++) begin
            logic [7:0] d;
            bit         b8, pen, odd, flip, sok, rd;
            d    = 8'($urandom);
            b8   = 1'($urandom_range(0, 1));
            pen  = 1'($urandom_range(0, 1));
            odd  = 1'($urandom_range(0, 1));
            flip = pen ? 1'($urandom_range(0, 1)) : 1'b0;
            sok  = ($urandom_range(0, 3) != 0);
            rd   = ($urandom_range(0, 2) != 0);
            if (!b8) d[7] = 1'b0;
            if (!sok && d == 8'h00) d = 8'h01;
            if (rd) begin
                do_read();
                m_read();
            end
            send(d, b8, pen, odd, flip, sok);
            m_complete(d, pen && flip, !sok);
            check_all($sformatf("rand%0d", r), m_data, m_rdy, m_pe, m_fe, m_ov);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_async.md
Name: uart_rx_async

Overview:
- Asynchronous UART receiver: the downstream peer of the UART transmitter; consumes the serial line that the transmitter drives.
- Oversamples the line on a 16x baud enable from the shared baud generator and recovers the start, data, parity and stop bits.
- Presents a parallel byte with ready, parity, framing and overrun status to the APB register/FIFO layer.
- Character format (7/8 data bits, parity enable, odd/even) uses the same control signals as the transmitter.

Parameters:
- OVERSAMPLE, 16, baud_pulse enables per bit period; legal values are 8 or 16.
- SAMPLE_POINT, 7, sample index within a bit period at which the bit is decided; must be < OVERSAMPLE-1.
- SYNC_STAGES, 2, flip-flops in the rx input synchronizer; range 2..3.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- baud_pulse  in  1  one-clk enable at OVERSAMPLE x baud rate.
- rx  in  1  asynchronous serial input; idle level is 1.
- bit8  in  1  1 = 8 data bits, 0 = 7 data bits.
- parity_en  in  1  parity bit present.
- odd_n_even  in  1  1 = odd parity, 0 = even parity.
- read_rx  in  1  one-clk strobe: consumer has taken rx_data.
- rx_data  out  8  received byte; bit7 = 0 in 7-bit mode.
- rx_rdy  out  1  rx_data valid and unread.
- parity_err  out  1  parity mismatch on the byte in rx_data.
- framing_err  out  1  stop bit sampled as 0 on the byte in rx_data.
- overflow  out  1  a byte was lost because rx_rdy was still set.

Behaviour:
- Reset: all outputs are 0. State is rx_idle, counters are 0, and the synchronizer and vote registers are all 1. Reset mid-frame abandons the frame; no partial byte is delivered.
- Synchronizer: rx passes through SYNC_STAGES flops.
- Vote register: 3-bit shift of the synchronized rx, shifted on every baud_pulse.
- vote = majority of the 3 bits in the vote register.
- Unless stated otherwise, all state and counter activity advances only on cycles where baud_pulse = 1.
- samp_cnt: width log2(OVERSAMPLE). It wraps from OVERSAMPLE-1 to 0, and each wrap starts the next bit period.
- State rx_idle: if the synchronized rx = 0, go to rx_start and set samp_cnt = 0.
- State rx_start: at samp_cnt == SAMPLE_POINT, check vote.
  - vote = 1: false start; return to rx_idle with no status change.
  - vote = 0: go to rx_data with bit_cnt = 0 and samp_cnt continuing.
- State rx_data: at each SAMPLE_POINT, shift vote into the shift register LSB-first and increment bit_cnt.
  - After the last data bit (bit_cnt = 7 in 8-bit mode, 6 in 7-bit mode), go to rx_parity if parity_en, otherwise to rx_stop.
- State rx_parity: at SAMPLE_POINT, capture vote as the received parity bit.
- Expected parity bit = odd_n_even XOR (XOR of the data bits), identical to the transmitter's rule.
- State rx_stop: at SAMPLE_POINT, evaluate the stop bit and go to rx_idle immediately; there is no wait for the end of the stop bit.
- Completion event (at the rx_stop sample), effective on the next clk:
  - rx_data <= assembled byte.
  - parity_err <= parity_en AND mismatch.
  - framing_err <= NOT vote.
  - rx_rdy <= 1.
- framing_err is reported but the byte is still delivered.
- read_rx with no completion in the same cycle: clears rx_rdy, parity_err, framing_err and overflow on the next clk.
- Completion while rx_rdy = 1 and no read_rx:
  - The new byte and its status are discarded; rx_data is unchanged.
  - overflow <= 1, sticky until read_rx.
- read_rx in the same cycle as completion: the new byte loads, rx_rdy stays 1, and overflow is cleared (not set).
- Changing bit8 or parity_en mid-frame is not supported. Software changes them only when the line is idle.
- Latency: rx_rdy asserts 1 clk after the baud_pulse that samples the stop bit.

Optional Feature:
- Macro: UART_RX_BREAK_DETECT_EN.
- Defined: adds output brk_det (1 bit, reset 0). It is set at a completion event when every data bit, the parity bit (if enabled) and the stop bit sampled 0.
  - The all-zero byte is not delivered: rx_rdy is unaffected and rx_data is unchanged.
  - framing_err is not set.
  - After a break, the FSM waits in rx_idle until the synchronized rx = 1 before a new start can be accepted.
  - brk_det is cleared by read_rx.
- Undefined: no brk_det port. A break is received as byte 0x00 with framing_err = 1.

Decomposition:
- Shared package uart_pkg holds:
  - rx state encoding constants: RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP.
  - the OVERSAMPLE default.
  - a parity function shared with the transmitter.
- One natural sub-module: uart_rx_sync_vote, containing the input synchronizer, the 3-sample vote register and the vote output.

Test Plan:
- 8N1 (bit8 = 1, parity_en = 0), send 0xA5 at 16x oversampling → rx_data = 0xA5, rx_rdy = 1, parity_err = framing_err = overflow = 0, exactly 1 clk after the stop sample.
- 7O1 (bit8 = 0, parity_en = 1, odd_n_even = 1), send 0x35 with a correct parity bit, then with the parity bit inverted → rx_data = 0x35; parity_err = 0, then 1.
- 3-baud_pulse low glitch on an idle line → FSM returns to rx_idle and rx_rdy stays 0.
- Single-sample 1 spike at SAMPLE_POINT of a 0 data bit → vote still yields 0 and the byte is correct.
- Send 0x11 and 0x22 with no read_rx → rx_data = 0x11 and overflow = 1.
  - Then read_rx → all flags clear.
  - Repeat with read_rx coincident with the 0x22 completion → rx_data = 0x22, rx_rdy = 1, overflow = 0.
- Stop bit forced to 0 with byte 0x5A → rx_data = 0x5A and framing_err = 1.
  - With UART_RX_BREAK_DETECT_EN, line held low for 12 bit times → brk_det = 1, rx_rdy = 0.
  - Reset asserted mid-byte → all outputs 0, and the next clean byte is received correctly.
